// File: rtl/ddr2_64bit_ex_pattern_ctrl.sv
// Write/read-back sequencer for the DDR2 64-bit example driver: replays the
// byte-lane LFSR stream for write data and for expected read data, then reports status.
module ddr2_64bit_ex_pattern_ctrl #(
    parameter int                NUM_BEATS = 16,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              lfsr_enable,
    output logic              lfsr_pause,
    input  logic [63:0]       lfsr_data,
    output logic              local_write_req,
    output logic              local_read_req,
    output logic [ADDR_W-1:0] local_addr,
    input  logic              local_ready,
    input  logic              local_rdata_valid,
    input  logic [63:0]       local_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [7:0]        err_count
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_BEATS - 1);
    localparam logic [CNT_W-1:0]  RX_BEATS  = CNT_W'(NUM_BEATS);
    localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(NUM_BEATS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_INIT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RD_INIT = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_WAIT_RD = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Visible FSM state for bound checkers.
    logic [2:0]        state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [CNT_W-1:0]  rx_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic wr_fire;
    logic rd_fire;
    logic rx_phase;
    logic rx_fire;
    logic mismatch;

    // Handshake: a request stays asserted with a stable address (and stable
    // lfsr_data for writes) until the cycle where req && local_ready, which is
    // the single transfer point; read data is taken whenever local_rdata_valid.
    assign wr_fire  = local_write_req && local_ready;
    assign rd_fire  = local_read_req && local_ready;
    assign rx_phase = (state == S_READ) || (state == S_WAIT_RD);
    assign rx_fire  = rx_phase && local_rdata_valid && (rx_cnt < RX_BEATS);
    assign mismatch = local_rdata != lfsr_data;

    assign local_write_req = state == S_WRITE;
    assign local_read_req  = state == S_READ;
    assign lfsr_enable     = (state == S_WRITE) || rx_phase;
    // The LFSRs step only when the current word has been consumed.
    assign lfsr_pause      = !(wr_fire || rx_fire);
    assign busy            = (state != S_IDLE) && (state != S_DONE);
    assign done            = state == S_DONE;
    assign pass            = done && (err_count == 8'd0) && !timeout;

    always_comb begin
        local_addr = BASE_ADDR;
        if (state == S_WRITE) begin
            local_addr = BASE_ADDR + wr_cnt;
        end else if (state == S_READ) begin
            local_addr = BASE_ADDR + rd_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rx_cnt    <= '0;
            idle_cnt  <= '0;
            err_count <= 8'd0;
            timeout   <= 1'b0;
        end else begin
            idle_cnt <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_WR_INIT;
                        wr_cnt    <= '0;
                        rd_cnt    <= '0;
                        rx_cnt    <= '0;
                        err_count <= 8'd0;
                        timeout   <= 1'b0;
                    end
                end
                S_WR_INIT: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + ADDR_W'(1);
                        if (wr_cnt == LAST_BEAT) begin
                            state <= S_RD_INIT;
                        end
                    end
                end
                S_RD_INIT: begin
                    rd_cnt <= '0;
                    rx_cnt <= '0;
                    state  <= S_READ;
                end
                S_READ: begin
                    if (rd_fire) begin
                        rd_cnt <= rd_cnt + ADDR_W'(1);
                        if (rd_cnt == LAST_BEAT) begin
                            state <= S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    // The final beat closes the run on the edge it arrives.
                    if ((rx_cnt == RX_BEATS) || (rx_fire && (rx_cnt == RX_LAST))) begin
                        state <= S_DONE;
                    end else if (!local_rdata_valid) begin
                        if (idle_cnt == IDLE_LAST) begin
                            timeout <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (rx_fire) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
                if (mismatch && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr2_64bit_ex_pattern_ctrl.sv
// Bench for ddr2_64bit_ex_pattern_ctrl: lane LFSRs plus loopback memory around the
// main instance, and two small instances for address wrap and error saturation.
module tb_ddr2_64bit_ex_pattern_ctrl;

    localparam int          NB   = 4;
    localparam logic [63:0] SEED = 64'hA53C01FF7E42995A;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic        start = 1'b0;
    logic        lfsr_enable, lfsr_pause;
    logic [63:0] lfsr_data;
    logic        write_req, read_req;
    logic [23:0] addr;
    logic        ready = 1'b1;
    logic        rdata_valid;
    logic [63:0] rdata;
    logic        busy, done, pass, timeout;
    logic [7:0]  err_count;

    logic        ready_tog = 1'b0;
    logic        inj_valid = 1'b0;
    int          corrupt_idx = -1;
    int          drop_idx = -1;

    ddr2_64bit_ex_pattern_ctrl #(
        .NUM_BEATS(NB), .ADDR_W(24), .BASE_ADDR(24'd0), .TIMEOUT(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .lfsr_enable(lfsr_enable), .lfsr_pause(lfsr_pause), .lfsr_data(lfsr_data),
        .local_write_req(write_req), .local_read_req(read_req), .local_addr(addr),
        .local_ready(ready), .local_rdata_valid(rdata_valid), .local_rdata(rdata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
    );

    function automatic logic [63:0] lfsr_step(input logic [63:0] v);
        logic [63:0] n;
        logic [7:0]  b;
        for (int k = 0; k < 8; k++) begin
            b = v[8*k +: 8];
            n[8*k +: 8] = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
        end
        return n;
    endfunction

    function automatic logic [63:0] seq_at(input int n);
        logic [63:0] v = SEED;
        for (int i = 0; i < n; i++) v = lfsr_step(v);
        return v;
    endfunction

    // Eight lane LFSRs, shared enable/pause.
    logic [63:0] lfsr_q = SEED;
    assign lfsr_data = lfsr_q;
    always @(posedge clk) begin
        if (!lfsr_enable) lfsr_q <= SEED;
        else if (!lfsr_pause) lfsr_q <= lfsr_step(lfsr_q);
    end

    // Loopback memory: read data one cycle after each accepted read.
    logic [63:0] mem [16];
    logic        rv_q = 1'b0;
    logic [63:0] rdata_q = 64'h0;
    int          ret_idx = 0;
    always @(posedge clk) begin
        if (write_req && ready) mem[addr[3:0]] <= lfsr_data;
        rv_q <= 1'b0;
        if (start) ret_idx <= 0;
        if (read_req && ready) begin
            rv_q    <= (ret_idx != drop_idx);
            rdata_q <= mem[addr[3:0]] ^ ((ret_idx == corrupt_idx) ? 64'h20 : 64'h0);
            ret_idx <= ret_idx + 1;
        end
    end
    assign rdata_valid = rv_q | inj_valid;
    assign rdata       = inj_valid ? 64'hFFFF_FFFF_FFFF_FFFF : rdata_q;

    // ready driver: constant high, or alternating 1-0-1-0.
    initial begin
        forever begin
            @(posedge clk); #1;
            ready = ready_tog ? ~ready : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [63:0] exp_q[$];
    logic [63:0] rx_q[$];
    logic [63:0] wr_log[$];
    logic [63:0] ref_log[$];
    int          m_wr_i = 0;
    int          m_rd_i = 0;
    logic [7:0]  m_err = 8'd0;
    logic        rx_win, rx_ev, exp_en, exp_pause;

    task automatic model_reset(input bit fill);
        exp_q.delete();
        rx_q.delete();
        m_wr_i = 0;
        m_rd_i = 0;
        m_err  = 8'd0;
        if (fill) begin
            wr_log.delete();
            for (int i = 0; i < NB; i++) begin
                exp_q.push_back(seq_at(i));
                rx_q.push_back(seq_at(i));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset(1'b0);
        end else begin
            rx_win    = busy && (read_req || (m_rd_i > 0));
            rx_ev     = rx_win && rdata_valid && (rx_q.size() > 0);
            exp_en    = write_req || read_req || (busy && (m_rd_i == NB));
            exp_pause = !((write_req && ready) || rx_ev);
            chk("req_exclusive", write_req && read_req, 1'b0);
            chk("lfsr_enable", lfsr_enable, exp_en);
            chk("lfsr_pause", lfsr_pause, exp_pause);
            chk("err_count", err_count, m_err);
            chk("done_not_busy", done && busy, 1'b0);
            if (busy) begin
                chk("pass_while_busy", pass, 1'b0);
                chk("timeout_while_busy", timeout, 1'b0);
            end
            if (done) begin
                chk("pass_at_done", pass, (m_err == 0) && (rx_q.size() == 0));
                chk("timeout_at_done", timeout, rx_q.size() != 0);
            end
            if (write_req) begin
                chk("wr_addr", addr, 24'(m_wr_i));
                chk("wr_data", lfsr_data, (exp_q.size() > 0) ? exp_q[0] : 64'hX);
                if (ready && exp_q.size() > 0) begin
                    wr_log.push_back(lfsr_data);
                    void'(exp_q.pop_front());
                    m_wr_i++;
                end
            end
            if (read_req) begin
                chk("rd_after_writes", 32'(m_wr_i), 32'(NB));
                chk("rd_addr", addr, 24'(m_rd_i));
                if (ready) m_rd_i++;
            end
            if (rx_ev) begin
                chk("rx_replay", lfsr_data, rx_q[0]);
                if ((rdata != rx_q[0]) && (m_err != 8'hFF)) m_err = m_err + 8'd1;
                void'(rx_q.pop_front());
            end
            if (start && !busy) model_reset(1'b1);
        end
    end

    // ---------------- wrap instance: ADDR_W=4, BASE_ADDR=14 ----------------
    logic       w_start = 1'b0;
    logic       w_en, w_pause, w_wreq, w_rreq, w_busy, w_done, w_pass, w_to;
    logic [3:0] w_addr;
    logic [7:0] w_err;
    logic       w_valid_q = 1'b0;
    logic [3:0] w_addr_q[$];
    always @(posedge clk) w_valid_q <= w_rreq;
    always @(negedge clk) if (reset_n && (w_wreq || w_rreq)) w_addr_q.push_back(w_addr);

    ddr2_64bit_ex_pattern_ctrl #(
        .NUM_BEATS(4), .ADDR_W(4), .BASE_ADDR(4'd14), .TIMEOUT(10)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .start(w_start),
        .lfsr_enable(w_en), .lfsr_pause(w_pause), .lfsr_data(64'h0),
        .local_write_req(w_wreq), .local_read_req(w_rreq), .local_addr(w_addr),
        .local_ready(1'b1), .local_rdata_valid(w_valid_q), .local_rdata(64'h0),
        .busy(w_busy), .done(w_done), .pass(w_pass), .timeout(w_to), .err_count(w_err)
    );

    // ---------------- saturation instance: 300 beats, all corrupt ----------------
    logic        s_start = 1'b0;
    logic        s_en, s_pause, s_wreq, s_rreq, s_busy, s_done, s_pass, s_to;
    logic [23:0] s_addr;
    logic [7:0]  s_err;
    logic        s_valid_q = 1'b0;
    always @(posedge clk) s_valid_q <= s_rreq;

    ddr2_64bit_ex_pattern_ctrl #(
        .NUM_BEATS(300), .ADDR_W(24), .BASE_ADDR(24'd0), .TIMEOUT(255)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(s_start),
        .lfsr_enable(s_en), .lfsr_pause(s_pause), .lfsr_data(64'h0),
        .local_write_req(s_wreq), .local_read_req(s_rreq), .local_addr(s_addr),
        .local_ready(1'b1), .local_rdata_valid(s_valid_q), .local_rdata(64'hFFFF_FFFF_FFFF_FFFF),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_to), .err_count(s_err)
    );

    // ---------------- driver tasks ----------------
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_lfsr_enable"}, lfsr_enable, 1'b0);
        chk({tag, "_lfsr_pause"}, lfsr_pause, 1'b1);
        chk({tag, "_write_req"}, write_req, 1'b0);
        chk({tag, "_read_req"}, read_req, 1'b0);
        chk({tag, "_addr"}, addr, 24'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass"}, pass, 1'b0);
        chk({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_err_count"}, err_count, 8'd0);
    endtask

    // Pulses start, then waits (bounded) for done; cycle 1 is the WR_INIT cycle.
    task automatic run_main(input bit mid_evt, output int cyc, output int last_v);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        last_v = -1;
        chk("init_busy", busy, 1'b1);
        chk("init_reseed", lfsr_enable, 1'b0);
        chk("init_no_req", write_req | read_req, 1'b0);
        chk("init_err_cleared", err_count, 8'd0);
        chk("init_done_cleared", done, 1'b0);
        chk("init_pass_cleared", pass, 1'b0);
        chk("init_timeout_cleared", timeout, 1'b0);
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            start = 1'b0;
            inj_valid = 1'b0;
            cyc++;
            if (rdata_valid) last_v = cyc;
            if (cyc == 2) chk("first_write_req", write_req, 1'b1);
            if (mid_evt && cyc == 3) start = 1'b1;
            if (mid_evt && cyc == 4) inj_valid = 1'b1;
        end
        chk("done_reached", done, 1'b1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc, lv, k;
        logic [3:0] wa;

        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        reset_n = 1'b1;

        // Model pins: first two words of the replayed stream.
        chk("seq0_literal", seq_at(0), 64'hA53C01FF7E42995A);
        chk("seq1_literal", seq_at(1), 64'h4A7902FEFD8433B4);

        // Stray read data while idle is ignored.
        @(posedge clk); #1 inj_valid = 1'b1;
        @(posedge clk); #1 inj_valid = 1'b0;
        chk("idle_valid_ignored", err_count, 8'd0);

        // Run 1: ready always high.
        run_main(1'b0, cyc, lv);
        chk("run1_cycles", cyc, 12);
        chk("run1_pass", pass, 1'b1);
        chk("run1_beats_written", wr_log.size(), NB);
        ref_log = wr_log;
        chk("run1_beat0_data", ref_log[0], 64'hA53C01FF7E42995A);
        chk("run1_beat1_data", ref_log[1], 64'h4A7902FEFD8433B4);

        // Run 2: ready toggling; same write stream.
        ready_tog = 1'b1;
        run_main(1'b0, cyc, lv);
        ready_tog = 1'b0;
        chk("run2_pass", pass, 1'b1);
        chk("run2_beats_written", wr_log.size(), NB);
        for (int i = 0; i < NB; i++) chk("run2_same_stream", wr_log[i], ref_log[i]);

        // Run 3: bit 5 of beat 2 corrupted.
        corrupt_idx = 2;
        run_main(1'b0, cyc, lv);
        corrupt_idx = -1;
        chk("run3_err_count", err_count, 8'd1);
        chk("run3_pass", pass, 1'b0);

        // Run 4: last beat never returned; rerun also clears run 3 status.
        drop_idx = 3;
        run_main(1'b0, cyc, lv);
        drop_idx = -1;
        chk("run4_timeout", timeout, 1'b1);
        chk("run4_pass", pass, 1'b0);
        chk("run4_last_valid_cycle", lv, 10);
        chk("run4_idle_gap", cyc - lv, 11);

        // Run 5: start and stray valid during WRITE, extra valid after done.
        run_main(1'b1, cyc, lv);
        chk("run5_cycles", cyc, 12);
        @(posedge clk); #1 inj_valid = 1'b1;
        @(posedge clk); #1 inj_valid = 1'b0;
        @(posedge clk); #1;
        chk("run5_extra_valid_err", err_count, 8'd0);
        chk("run5_pass", pass, 1'b1);
        chk("run5_done_held", done, 1'b1);

        // Run 6: reset in the middle of READ.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (!read_req && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("run6_reached_read", read_req, 1'b1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1 chk_reset_vals("mid_read_reset");
        @(posedge clk); #1 reset_n = 1'b1;

        // Address wrap instance: 14, 15, 0, 1 on both passes.
        w_addr_q.delete();
        @(posedge clk); #1 w_start = 1'b1;
        @(posedge clk); #1 w_start = 1'b0;
        k = 1;
        while (!w_done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wrap_done", w_done, 1'b1);
        chk("wrap_cycles", k, 12);
        chk("wrap_pass", w_pass, 1'b1);
        chk("wrap_req_count", w_addr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            wa = 4'd14 + 4'(i % 4);
            chk("wrap_addr", w_addr_q[i], wa);
        end

        // Saturation instance: every one of 300 beats mismatches.
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        k = 1;
        while (!s_done && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("sat_done", s_done, 1'b1);
        chk("sat_cycles", k, 2 + 300 + 1 + 300 + 1);
        chk("sat_err_count", s_err, 8'hFF);
        chk("sat_pass", s_pass, 1'b0);
        chk("sat_timeout", s_to, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ddr2_64bit_ex_pattern_ctrl.md
# ddr2_64bit_ex_pattern_ctrl

Sequencer for the DDR2 64-bit example driver's pattern generators. It runs one write pass and one read-back pass over NUM_BEATS consecutive local-interface addresses. It drives the shared enable/pause controls of the eight byte-lane 8-bit LFSRs so the same pseudo-random stream is replayed for write data and for expected read data. It compares returned data against the replayed stream and reports pass/fail, error count and timeout.

## Interface
Parameters:
- NUM_BEATS, 16: local beats per pass (1..2^ADDR_W).
- ADDR_W, 24: local address width.
- BASE_ADDR, 0: first address of each pass.
- TIMEOUT, 255: max consecutive idle cycles in WAIT_RD before abort (≥1).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a test run when in IDLE or DONE.
- lfsr_enable  out  1  to all lane LFSRs; low forces them to seed.
- lfsr_pause  out  1  to all lane LFSRs; high freezes them.
- lfsr_data  in  64  concatenated lane LFSR outputs; also routed externally as write data.
- local_write_req  out  1  write request.
- local_read_req  out  1  read request.
- local_addr  out  ADDR_W  request address.
- local_ready  in  1  controller accepts current request this cycle.
- local_rdata_valid  in  1  read data beat valid.
- local_rdata  in  64  read data.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid when done: no errors and no timeout.
- timeout  out  1  read-back aborted by TIMEOUT.
- err_count  out  8  mismatching beats, saturates at 255.

## Operation
- States: IDLE, WR_INIT, WRITE, RD_INIT, READ, WAIT_RD, DONE.
- IDLE/DONE + start → WR_INIT. Entering WR_INIT clears err_count, timeout, pass, done and both beat counters.
- WR_INIT: lfsr_enable=0 for one cycle, which reseeds the LFSRs. → WRITE.
- WRITE: local_write_req=1, local_addr=BASE_ADDR+wr_cnt, wrapping mod 2^ADDR_W.
  - A beat is accepted when req&&ready. The address and lfsr_data are held stable until acceptance.
  - lfsr_pause = !(local_write_req && local_ready), combinational, so the LFSR advances exactly once per accepted beat.
  - After the NUM_BEATS-th acceptance → RD_INIT.
- RD_INIT: lfsr_enable=0 for one cycle (reseed), read counters cleared. → READ.
- READ: local_read_req=1, local_addr=BASE_ADDR+rd_cnt. rd_cnt increments on req&&ready. After the NUM_BEATS-th acceptance → WAIT_RD.
- READ and WAIT_RD: on local_rdata_valid with rx_cnt<NUM_BEATS:
  - compare local_rdata to lfsr_data; on mismatch, err_count += 1 (saturating);
  - rx_cnt increments;
  - lfsr_pause = !(local_rdata_valid && rx_cnt<NUM_BEATS).
- WAIT_RD → DONE when rx_cnt==NUM_BEATS, including the cycle the last valid arrives.
- WAIT_RD idle counter: counts cycles without valid and clears on valid. Reaching TIMEOUT sets timeout=1 → DONE.
- DONE: done=1, busy=0, pass=(err_count==0 && !timeout). lfsr_enable=0.
- Ignored events:
  - start while busy;
  - rdata_valid in IDLE, WR_INIT, WRITE, RD_INIT and DONE;
  - rdata_valid beyond NUM_BEATS.
- Requests: write_req and read_req are never high together. A req drops the cycle after its final acceptance. A req is never withdrawn before acceptance.

## Timing
- Reset values:
  - state IDLE;
  - lfsr_enable=0, lfsr_pause=1;
  - local_write_req=0, local_read_req=0, local_addr=BASE_ADDR;
  - busy=0, done=0, pass=0, timeout=0, err_count=0.
- Outside WRITE/READ/WAIT_RD, lfsr_pause=1. lfsr_enable=1 only in WRITE, READ and WAIT_RD.
- start at edge N → WR_INIT in cycle N+1 (busy=1). First write_req in cycle N+2.
- Full run with ready and valid always high (valid one cycle after each read acceptance), ignoring lfsr output registration: 2 + NUM_BEATS + 1 + NUM_BEATS + 1 cycles to done.
- err_count and rx_cnt update at the edge of the valid cycle. done rises the cycle after the last valid.
- Reset mid-run: immediate return to reset values. No partial status is retained.

## Test plan
- NUM_BEATS=4, ready=1, loopback memory returns written data one cycle after each read → write addresses 0..3, read addresses 0..3, done=1, pass=1, err_count=0, in 12 cycles after start.
- Same, with ready toggling 1-0-1-0 → each address held until accepted; lfsr_pause high on non-accept cycles; write data sequence identical to the ready=1 run; pass=1.
- Memory corrupts bit 5 of beat 2 → err_count=1, pass=0. Corrupt all beats of a 300-beat run → err_count saturates at 255.
- Memory returns only 3 of 4 beats, TIMEOUT=10 → timeout=1 exactly 10 idle cycles after the last valid, done=1, pass=0. An extra 5th valid in another run is ignored.
- start pulsed during WRITE → no effect. Rerun from DONE → status cleared in WR_INIT and results reproduced. reset_n low mid-READ → all outputs at reset values on the same cycle.
- ADDR_W=4, BASE_ADDR=14, NUM_BEATS=4 → addresses 14, 15, 0, 1 on both passes.
